iterative_multiplier: RTL and testbench

- Multi-cycle shift-add multiplier for the M-extension datapath; the multiply counterpart to the core's iterative divider.
- Same operand and handshake shape as the divider: two operands with per-operand signedness, an `enable` start, and a `data_valid` completion pulse.
- Produces the full 2*WIDTH product so one unit serves MUL, MULH, MULHSU and MULHU.
- The execute stage selects `output_low` or `output_high`.

---
 rtl/iterative_multiplier.sv | 142 ++++++++++++++
 tb/tb_iterative_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier.sv
// Iterative shift-add multiplier producing the full 2*WIDTH product.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle on operand magnitudes,
// then applies the result sign once on the DONE entry edge.
// Optional build macro: MUL_EARLY_OUT_EN (finish as soon as the remaining
// multiplier bits are all zero; results are identical either way).
module iterative_multiplier #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             signed_a,
  input  logic             signed_b,
  input  logic             enable,
  output logic [WIDTH-1:0] output_low,
  output logic [WIDTH-1:0] output_high,
  output logic             data_valid,
  output logic             busy
);

  localparam int unsigned ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] scan;

  // Operand magnitudes; the most-negative value maps onto itself as unsigned 2^(WIDTH-1)
  assign a_neg = signed_a & input_a[WIDTH-1];
  assign b_neg = signed_b & input_b[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(~input_a + WIDTH'(1)) : input_a;
  assign b_mag = b_neg ? WIDTH'(~input_b + WIDTH'(1)) : input_b;
  assign prod  = neg_q ? PW'(~acc_q + PW'(1)) : acc_q;

  // State, datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      low_q    <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      low_q    <= low_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, iteration step and result load
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    low_d    = low_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    scan     = mplier_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (enable) begin
          state_d  = S_BUSY;
          mcand_d  = {WIDTH'(0), a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CNT_W'(ITERS);
          neg_d    = a_neg ^ b_neg;
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          // Counter exhausted: publish the signed product for one valid cycle
          state_d = S_DONE;
          valid_d = 1'b1;
          low_d   = prod[WIDTH-1:0];
          high_d  = prod[PW-1:WIDTH];
        end else begin
          busy_d = 1'b1;
          for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (scan[0]) acc_d = acc_d + (mcand_q << i);
            scan = scan >> 1;
          end
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q - CNT_W'(1);
`ifdef MUL_EARLY_OUT_EN
          // Multiplicand is pre-shifted, so the accumulator is already aligned and final
          if (mplier_d == '0) cnt_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign output_low  = low_q;
  assign output_high = high_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed self-checking bench for iterative_multiplier (WIDTH=32, BITS_PER_CYCLE=1).
module tb_iterative_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        signed_a = 1'b0;
  logic        signed_b = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] output_low;
  logic [31:0] output_high;
  logic        data_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .input_a    (input_a),
    .input_b    (input_b),
    .signed_a   (signed_a),
    .signed_b   (signed_b),
    .enable     (enable),
    .output_low (output_low),
    .output_high(output_high),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Edges from accept to data_valid for a given multiplier operand
  function automatic int exp_lat(input logic [31:0] b, input logic sb);
    logic [31:0] m;
    int          k;
    m = (sb && b[31]) ? (~b + 32'd1) : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    if (k == 0) k = 1;
    return EARLY ? (k + 1) : 33;
  endfunction

  // Start one operation and wait (bounded) for data_valid; returns at the DONE-cycle negedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    @(negedge clock);
    input_a = a; input_b = b; signed_a = sa; signed_b = sb; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    lat = 0;
    while (data_valid !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    hi = output_high;
    lo = output_low;
  endtask

  task automatic test_reset();
    input_a = 32'd5; input_b = 32'd6; enable = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid); end
    total++; if (output_low !== 32'h0) begin bad++; $display("FAIL reset_low got=%h want=0", output_low); end
    total++; if (output_high !== 32'h0) begin bad++; $display("FAIL reset_high got=%h want=0", output_high); end
    enable = 1'b0;
    reset  = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_products();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vsa[6];
    logic        vsb[6];
    logic [31:0] eh [6];
    logic [31:0] el [6];
    logic [31:0] hi, lo;
    int          lat;
    va[0] = 32'd15634654; vb[0] = 32'd21354;     vsa[0] = 0; vsb[0] = 0; eh[0] = 32'h0000004D; el[0] = 32'hBBBFF5EC;
    va[1] = 32'hFFFFFFFD; vb[1] = 32'd5;         vsa[1] = 1; vsb[1] = 1; eh[1] = 32'hFFFFFFFF; el[1] = 32'hFFFFFFF1;
    va[2] = 32'h80000000; vb[2] = 32'h80000000;  vsa[2] = 1; vsb[2] = 1; eh[2] = 32'h40000000; el[2] = 32'h00000000;
    va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFF;  vsa[3] = 1; vsb[3] = 0; eh[3] = 32'hFFFFFFFF; el[3] = 32'h00000001;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'hFFFFFFFF;  vsa[4] = 0; vsb[4] = 0; eh[4] = 32'hFFFFFFFE; el[4] = 32'h00000001;
    va[5] = 32'd7;        vb[5] = 32'hFFFFFFFE;  vsa[5] = 0; vsb[5] = 1; eh[5] = 32'hFFFFFFFF; el[5] = 32'hFFFFFFF2;
    for (int v = 0; v < 6; v++) begin
      issue(va[v], vb[v], vsa[v], vsb[v], hi, lo, lat);
      total++; if (lat != exp_lat(vb[v], vsb[v])) begin bad++; $display("FAIL prod%0d_latency got=%0d want=%0d", v, lat, exp_lat(vb[v], vsb[v])); end
      total++; if (hi !== eh[v]) begin bad++; $display("FAIL prod%0d_high got=%h want=%h", v, hi, eh[v]); end
      total++; if (lo !== el[v]) begin bad++; $display("FAIL prod%0d_low got=%h want=%h", v, lo, el[v]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL prod%0d_busy_done got=%b want=0", v, busy); end
      @(negedge clock);
      total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL prod%0d_valid_width got=%b want=0", v, data_valid); end
      total++; if (output_low !== el[v]) begin bad++; $display("FAIL prod%0d_low_hold got=%h want=%h", v, output_low, el[v]); end
    end
  endtask

  task automatic test_busy_protocol();
    int          pulses = 0;
    int          at = -1;
    logic [31:0] hi = '0, lo = '0;
    @(negedge clock);
    input_a = 32'd1000; input_b = 32'h80000000; signed_a = 0; signed_b = 0; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy_high got=%b want=1", busy); end
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      if (c == 5 || c == 20) begin
        input_a = 32'hDEAD0000 + 32'(c); input_b = 32'h00001234; signed_a = 1; signed_b = 1; enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
      if (data_valid === 1'b1) begin
        pulses++;
        at = c;
        hi = output_high;
        lo = output_low;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL bp_pulses got=%0d want=1", pulses); end
    total++; if (at != 33) begin bad++; $display("FAIL bp_latency got=%0d want=33", at); end
    total++; if (hi !== 32'h000001F4) begin bad++; $display("FAIL bp_high got=%h want=000001f4", hi); end
    total++; if (lo !== 32'h00000000) begin bad++; $display("FAIL bp_low got=%h want=00000000", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int          lat;
    int          n;
    issue(32'd2, 32'h80000000, 1'b0, 1'b0, hi, lo, lat);
    total++; if (hi !== 32'h1 || lo !== 32'h0) begin bad++; $display("FAIL b2b_first got=%h_%h want=00000001_00000000", hi, lo); end
    input_a = 32'd9; input_b = 32'h80000001; signed_a = 0; signed_b = 0; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
    total++; if (output_high !== 32'h1) begin bad++; $display("FAIL b2b_hold_high got=%h want=00000001", output_high); end
    n = 0;
    while (data_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++; if (n + 1 != 34) begin bad++; $display("FAIL b2b_interval got=%0d want=34", n + 1); end
    total++; if (output_high !== 32'h4 || output_low !== 32'h80000009) begin
      bad++; $display("FAIL b2b_second got=%h_%h want=00000004_80000009", output_high, output_low);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int          lat;
    int          stray = 0;
    @(negedge clock);
    input_a = 32'h00012345; input_b = 32'h80000000; signed_a = 0; signed_b = 0; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (output_low !== 32'h0 || output_high !== 32'h0) begin
      bad++; $display("FAIL rmid_outputs got=%h_%h want=0_0", output_high, output_low);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (data_valid !== 1'b0) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL rmid_stray_valid got=%0d want=0", stray); end
    issue(32'd7, 32'd6, 1'b0, 1'b0, hi, lo, lat);
    total++; if (lat != exp_lat(32'd6, 1'b0)) begin bad++; $display("FAIL rmid_latency got=%0d want=%0d", lat, exp_lat(32'd6, 1'b0)); end
    total++; if (lo !== 32'd42 || hi !== 32'd0) begin bad++; $display("FAIL rmid_restart got=%h_%h want=00000000_0000002a", hi, lo); end
  endtask

`ifdef MUL_EARLY_OUT_EN
  task automatic test_early_out();
    logic [31:0] hi, lo;
    int          lat;
    issue(32'd12345, 32'd0, 1'b0, 1'b0, hi, lo, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL eo_zero_latency got=%0d want=2", lat); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL eo_zero_product got=%h_%h want=0_0", hi, lo); end
    issue(32'd3, 32'h00000010, 1'b0, 1'b0, hi, lo, lat);
    total++; if (lat != 6) begin bad++; $display("FAIL eo_small_latency got=%0d want=6", lat); end
    total++; if (lo !== 32'h30 || hi !== 32'h0) begin bad++; $display("FAIL eo_small_product got=%h_%h want=00000000_00000030", hi, lo); end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_products();
    test_busy_protocol();
    test_back_to_back();
    test_reset_mid();
`ifdef MUL_EARLY_OUT_EN
    test_early_out();
`endif
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
